// File: rtl/mem_cmd_rr_arbiter.sv
// mem_cmd_rr_arbiter: shares one memory/DMA command channel between NUM_REQ requesters.
// Round-robin grant onto a registered command port, per-requester outstanding limits, and an
// in-order ID FIFO that steers each returned status word back to the requester that issued it.
module mem_cmd_rr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = 64,
  parameter int LEN_W           = 32,
  parameter int STATUS_W        = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_FIFO_DEPTH   = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_REQ-1:0]          s_cmd_valid,
  output logic [NUM_REQ-1:0]          s_cmd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_cmd_address,
  input  logic [NUM_REQ*LEN_W-1:0]    s_cmd_length,
  output logic                        m_cmd_valid,
  input  logic                        m_cmd_ready,
  output logic [ADDR_W-1:0]           m_cmd_address,
  output logic [LEN_W-1:0]            m_cmd_length,
  input  logic                        s_status_valid,
  output logic                        s_status_ready,
  input  logic [STATUS_W-1:0]         s_status_data,
  output logic [NUM_REQ-1:0]          m_status_valid,
  input  logic [NUM_REQ-1:0]          m_status_ready,
  output logic [STATUS_W-1:0]         m_status_data,
  output logic                        busy,
  output logic                        err_orphan
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W  = $clog2(ID_FIFO_DEPTH);
  localparam int FCNT_W = $clog2(ID_FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(ID_FIFO_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Registered state
  logic                 m_cmd_valid_q, m_cmd_valid_d;
  logic [ADDR_W-1:0]    m_cmd_address_q, m_cmd_address_d;
  logic [LEN_W-1:0]     m_cmd_length_q, m_cmd_length_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     outstanding_q [NUM_REQ];
  logic [CNT_W-1:0]     outstanding_d [NUM_REQ];
  logic [IDX_W-1:0]     fifo_mem_q [ID_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    fifo_count_q, fifo_count_d;
  logic                 err_orphan_q, err_orphan_d;
  logic                 busy_q, busy_d;

  // Combinational helpers
  logic [NUM_REQ-1:0]   eligible;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 load;
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand_idx;
  logic                 accept;
  logic [ADDR_W-1:0]    sel_address;
  logic [LEN_W-1:0]     sel_length;
  logic [IDX_W-1:0]     head;
  logic                 pop;
  logic                 orphan;

  assign fifo_full  = (fifo_count_q == FULL_CNT);
  assign fifo_empty = (fifo_count_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];
  assign load       = !fifo_full && (!m_cmd_valid_q || m_cmd_ready);
  assign accept     = aresetn && load && grant_found;

  // A requester may compete only while it has room under its outstanding limit
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = s_cmd_valid[i] && (outstanding_q[i] < MAX_CNT);
    end
  end

  // Round-robin search: first eligible index at or above the pointer, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // One-hot ready to the winner only; held low while reset is asserted
  always_comb begin
    s_cmd_ready = '0;
    if (accept) begin
      s_cmd_ready[grant_idx] = 1'b1;
    end
  end

  // Pick the winner's address/length off the flattened request buses
  always_comb begin
    sel_address = '0;
    sel_length  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_address = s_cmd_address[i*ADDR_W +: ADDR_W];
        sel_length  = s_cmd_length[i*LEN_W +: LEN_W];
      end
    end
  end

  // Steer status to the FIFO head; with no command outstanding the word is swallowed as an orphan
  always_comb begin
    m_status_valid = '0;
    s_status_ready = 1'b0;
    pop            = 1'b0;
    orphan         = 1'b0;
    if (aresetn) begin
      if (fifo_empty) begin
        s_status_ready = 1'b1;
        orphan         = s_status_valid;
      end else begin
        m_status_valid[head] = s_status_valid;
        s_status_ready       = m_status_ready[head];
        pop                  = s_status_valid && m_status_ready[head];
      end
    end
  end

  // Next-state for the command register, RR pointer, ID FIFO, counters and flags
  always_comb begin
    m_cmd_valid_d   = m_cmd_valid_q;
    m_cmd_address_d = m_cmd_address_q;
    m_cmd_length_d  = m_cmd_length_q;
    rr_ptr_d        = rr_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    fifo_count_d    = fifo_count_q;
    err_orphan_d    = err_orphan_q | orphan;

    if (accept) begin
      m_cmd_valid_d   = 1'b1;
      m_cmd_address_d = sel_address;
      m_cmd_length_d  = sel_length;
      rr_ptr_d        = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else if (m_cmd_ready) begin
      m_cmd_valid_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({accept, pop})
      2'b10:   fifo_count_d = fifo_count_q + FCNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - FCNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    for (int i = 0; i < NUM_REQ; i++) begin
      outstanding_d[i] = outstanding_q[i];
      if (accept && (grant_idx == IDX_W'(i)) && !(pop && (head == IDX_W'(i)))) begin
        outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
      end else if (pop && (head == IDX_W'(i)) && !(accept && (grant_idx == IDX_W'(i)))) begin
        outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
      end
    end

    busy_d = m_cmd_valid_d || (fifo_count_d != '0);
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_cmd_valid_q   <= 1'b0;
      m_cmd_address_q <= '0;
      m_cmd_length_q  <= '0;
      rr_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_count_q    <= '0;
      err_orphan_q    <= 1'b0;
      busy_q          <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outstanding_q[i] <= '0;
      end
    end else begin
      m_cmd_valid_q   <= m_cmd_valid_d;
      m_cmd_address_q <= m_cmd_address_d;
      m_cmd_length_q  <= m_cmd_length_d;
      rr_ptr_q        <= rr_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_count_q    <= fifo_count_d;
      err_orphan_q    <= err_orphan_d;
      busy_q          <= busy_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        outstanding_q[i] <= outstanding_d[i];
      end
    end
  end

  // ID FIFO storage; contents are meaningless once the pointers are reset, so no reset here
  always_ff @(posedge aclk) begin
    if (accept) begin
      fifo_mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign m_cmd_valid   = m_cmd_valid_q;
  assign m_cmd_address = m_cmd_address_q;
  assign m_cmd_length  = m_cmd_length_q;
  assign m_status_data = s_status_data;
  assign busy          = busy_q;
  assign err_orphan    = err_orphan_q;

endmodule

// File: tb/tb_mem_cmd_rr_arbiter.sv
// Testbench for mem_cmd_rr_arbiter: directed vector table, hand-written corner sequences and a
// randomized run, all compared against a queue-based model of the arbiter's documented rules.
module tb_mem_cmd_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 64;
  localparam int LEN_W   = 32;
  localparam int STS_W   = 8;
  localparam int MAX_OUT = 8;
  localparam int DEPTH   = 16;

  logic                      aclk = 1'b0;
  logic                      aresetn;
  logic [NUM_REQ-1:0]        s_cmd_valid;
  logic [NUM_REQ-1:0]        s_cmd_ready;
  logic [NUM_REQ*ADDR_W-1:0] s_cmd_address;
  logic [NUM_REQ*LEN_W-1:0]  s_cmd_length;
  logic                      m_cmd_valid;
  logic                      m_cmd_ready;
  logic [ADDR_W-1:0]         m_cmd_address;
  logic [LEN_W-1:0]          m_cmd_length;
  logic                      s_status_valid;
  logic                      s_status_ready;
  logic [STS_W-1:0]          s_status_data;
  logic [NUM_REQ-1:0]        m_status_valid;
  logic [NUM_REQ-1:0]        m_status_ready;
  logic [STS_W-1:0]          m_status_data;
  logic                      busy;
  logic                      err_orphan;

  always #5 aclk = ~aclk;

  mem_cmd_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .STATUS_W(STS_W),
    .MAX_OUTSTANDING(MAX_OUT), .ID_FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
    .s_status_valid(s_status_valid), .s_status_ready(s_status_ready),
    .s_status_data(s_status_data),
    .m_status_valid(m_status_valid), .m_status_ready(m_status_ready),
    .m_status_data(m_status_data),
    .busy(busy), .err_orphan(err_orphan)
  );

  // Reference model: issued-ID queue, per-requester outstanding counts, RR pointer, output register
  int                 id_q[$];
  int                 outs [NUM_REQ];
  int                 rr;
  bit                 mv;
  logic [ADDR_W-1:0]  maddr;
  logic [LEN_W-1:0]   mlen;
  bit                 err;
  int                 ev_grant;
  bit                 ev_pop;
  bit                 ev_orphan;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic               mrdy;
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_mvalid;
    logic [ADDR_W-1:0]  exp_addr;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic mrdy,
                               input logic svalid, input logic [STS_W-1:0] sdata,
                               input logic [NUM_REQ-1:0] msrdy);
    s_cmd_valid    = valid;
    m_cmd_ready    = mrdy;
    s_status_valid = svalid;
    s_status_data  = sdata;
    m_status_ready = msrdy;
  endtask

  task automatic setFixedAddresses();
    for (int i = 0; i < NUM_REQ; i++) begin
      s_cmd_address[i*ADDR_W +: ADDR_W] = 64'h1000 * (i + 1);
      s_cmd_length[i*LEN_W +: LEN_W]    = 32'h40 * (i + 1);
    end
  endtask

  task automatic modelReset();
    id_q.delete();
    for (int i = 0; i < NUM_REQ; i++) outs[i] = 0;
    rr = 0; mv = 0; maddr = '0; mlen = '0; err = 0;
  endtask

  task automatic doReset();
    applyStimulus('0, 1'b1, 1'b0, '0, '1);
    aresetn = 1'b0;
    modelReset();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  // Predict this cycle's outputs from the model and the driven inputs, then compare
  task automatic evalCycle();
    bit                 load;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_msv;
    logic               exp_ssr;
    int                 h;
    @(negedge aclk);
    load     = (id_q.size() < DEPTH) && (!mv || m_cmd_ready);
    ev_grant = -1;
    if (load) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (rr + k) % NUM_REQ;
        if (ev_grant < 0 && s_cmd_valid[idx] && outs[idx] < MAX_OUT) ev_grant = idx;
      end
    end
    exp_ready = (ev_grant >= 0) ? (NUM_REQ'(1) << ev_grant) : '0;
    ev_pop = 0; ev_orphan = 0; exp_msv = '0;
    if (id_q.size() == 0) begin
      exp_ssr   = 1'b1;
      ev_orphan = s_status_valid;
    end else begin
      h          = id_q[0];
      exp_msv[h] = s_status_valid;
      exp_ssr    = m_status_ready[h];
      ev_pop     = s_status_valid && m_status_ready[h];
    end
    checkOutput("s_cmd_ready", s_cmd_ready, exp_ready);
    checkOutput("m_cmd_valid", m_cmd_valid, mv);
    checkOutput("m_cmd_address", m_cmd_address, maddr);
    checkOutput("m_cmd_length", m_cmd_length, mlen);
    checkOutput("s_status_ready", s_status_ready, exp_ssr);
    checkOutput("m_status_valid", m_status_valid, exp_msv);
    if (exp_msv != '0) checkOutput("m_status_data", m_status_data, s_status_data);
    checkOutput("busy", busy, (mv || id_q.size() > 0));
    checkOutput("err_orphan", err_orphan, err);
  endtask

  // Advance the model across the clock edge using the same inputs the DUT sampled
  task automatic commitCycle();
    int h;
    @(posedge aclk);
    if (ev_pop) begin
      h = id_q.pop_front();
      outs[h]--;
    end
    if (ev_grant >= 0) begin
      id_q.push_back(ev_grant);
      outs[ev_grant]++;
      rr    = (ev_grant + 1) % NUM_REQ;
      mv    = 1;
      maddr = s_cmd_address[ev_grant*ADDR_W +: ADDR_W];
      mlen  = s_cmd_length[ev_grant*LEN_W +: LEN_W];
    end else if (mv && m_cmd_ready) begin
      mv = 0;
    end
    if (ev_orphan) err = 1;
    #1;
  endtask

  task automatic step();
    evalCycle();
    commitCycle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((id_q.size() > 0 || mv) && n < 60) begin
      applyStimulus('0, 1'b1, (id_q.size() > 0), STS_W'($urandom), '1);
      step();
      n++;
    end
    checkOutput("drain_empty", id_q.size(), 0);
    applyStimulus('0, 1'b1, 1'b0, '0, '1);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] held_addr;
    logic [LEN_W-1:0]  held_len;

    vecs[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 64'h0};
    vecs[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 64'h1000};
    vecs[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 64'h2000};
    vecs[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 64'h3000};
    vecs[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 64'h4000};
    vecs[5]  = '{4'hA, 1'b1, 4'b0010, 1'b1, 64'h1000};
    vecs[6]  = '{4'hA, 1'b1, 4'b1000, 1'b1, 64'h2000};
    vecs[7]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 64'h4000};
    vecs[8]  = '{4'h0, 1'b1, 4'b0000, 1'b0, 64'h4000};
    vecs[9]  = '{4'h1, 1'b1, 4'b0001, 1'b0, 64'h4000};
    vecs[10] = '{4'h1, 1'b0, 4'b0000, 1'b1, 64'h1000};
    vecs[11] = '{4'h1, 1'b0, 4'b0000, 1'b1, 64'h1000};
    vecs[12] = '{4'h2, 1'b1, 4'b0010, 1'b1, 64'h1000};
    vecs[13] = '{4'h0, 1'b1, 4'b0000, 1'b1, 64'h2000};

    setFixedAddresses();
    doReset();

    // Reset state
    evalCycle();
    checkOutput("reset_m_cmd_valid", m_cmd_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_err_orphan", err_orphan, 1'b0);
    commitCycle();

    // Directed vector table
    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].valid, vecs[v].mrdy, 1'b0, '0, '1);
      evalCycle();
      checkOutput($sformatf("vec%0d_ready", v), s_cmd_ready, vecs[v].exp_ready);
      checkOutput($sformatf("vec%0d_mvalid", v), m_cmd_valid, vecs[v].exp_mvalid);
      checkOutput($sformatf("vec%0d_addr", v), m_cmd_address, vecs[v].exp_addr);
      commitCycle();
    end
    drain();

    // T1: all requesting, status returned immediately -> 0,1,2,3,0,... one command per cycle
    doReset();
    for (int c = 0; c < 12; c++) begin
      applyStimulus('1, 1'b1, (c > 0), STS_W'(c), '1);
      evalCycle();
      checkOutput("t1_grant_order", s_cmd_ready, NUM_REQ'(1) << (c % NUM_REQ));
      if (c > 0) checkOutput("t1_m_cmd_valid", m_cmd_valid, 1'b1);
      commitCycle();
    end
    drain();

    // T2: requester 1 saturates its outstanding limit; others still served; one return frees it
    doReset();
    for (int c = 0; c < MAX_OUT; c++) begin
      applyStimulus(4'b0010, 1'b1, 1'b0, '0, '1);
      evalCycle();
      checkOutput("t2_accept", s_cmd_ready, 4'b0010);
      commitCycle();
    end
    applyStimulus(4'b0010, 1'b1, 1'b0, '0, '1);
    evalCycle();
    checkOutput("t2_ninth_held", s_cmd_ready, 4'b0000);
    commitCycle();
    applyStimulus(4'b0110, 1'b1, 1'b0, '0, '1);
    evalCycle();
    checkOutput("t2_req2_served", s_cmd_ready, 4'b0100);
    commitCycle();
    applyStimulus(4'b0010, 1'b1, 1'b1, 8'h5A, '1);
    evalCycle();
    checkOutput("t2_status_to_req1", m_status_valid, 4'b0010);
    checkOutput("t2_still_held", s_cmd_ready, 4'b0000);
    commitCycle();
    applyStimulus(4'b0010, 1'b1, 1'b0, '0, '1);
    evalCycle();
    checkOutput("t2_ninth_accepted", s_cmd_ready, 4'b0010);
    commitCycle();
    drain();

    // T3: downstream stall holds the command register and blocks all grants
    applyStimulus('1, 1'b1, 1'b0, '0, '1);
    step();
    held_addr = maddr;
    held_len  = mlen;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NUM_REQ; i++) s_cmd_address[i*ADDR_W +: ADDR_W] = {$urandom, $urandom};
      applyStimulus('1, 1'b0, 1'b0, '0, '1);
      evalCycle();
      checkOutput("t3_addr_stable", m_cmd_address, held_addr);
      checkOutput("t3_len_stable", m_cmd_length, held_len);
      checkOutput("t3_no_ready", s_cmd_ready, 4'b0000);
      commitCycle();
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus('1, 1'b1, 1'b0, '0, '1);
      step();
    end
    drain();

    // T4: issue 2,0,2 then statuses route in order; head 0 stalls while its ready is low
    setFixedAddresses();
    doReset();
    applyStimulus(4'b0100, 1'b1, 1'b0, '0, '1); step();
    applyStimulus(4'b0001, 1'b1, 1'b0, '0, '1); step();
    applyStimulus(4'b0100, 1'b1, 1'b0, '0, '1); step();
    applyStimulus(4'b0000, 1'b1, 1'b1, 8'hA1, 4'b1110);
    evalCycle();
    checkOutput("t4_a1_valid", m_status_valid, 4'b0100);
    checkOutput("t4_a1_data", m_status_data, 8'hA1);
    commitCycle();
    applyStimulus(4'b0000, 1'b1, 1'b1, 8'hA2, 4'b1110);
    evalCycle();
    checkOutput("t4_a2_valid", m_status_valid, 4'b0001);
    checkOutput("t4_a2_stalled", s_status_ready, 1'b0);
    commitCycle();
    applyStimulus(4'b0000, 1'b1, 1'b1, 8'hA2, 4'b1111);
    evalCycle();
    checkOutput("t4_a2_ready", s_status_ready, 1'b1);
    checkOutput("t4_a2_data", m_status_data, 8'hA2);
    commitCycle();
    applyStimulus(4'b0000, 1'b1, 1'b1, 8'hA3, 4'b1111);
    evalCycle();
    checkOutput("t4_a3_valid", m_status_valid, 4'b0100);
    checkOutput("t4_a3_data", m_status_data, 8'hA3);
    commitCycle();

    // T5: orphan status is accepted, not routed, and sets the sticky error
    applyStimulus(4'b0000, 1'b1, 1'b1, 8'h77, 4'b1111);
    evalCycle();
    checkOutput("t5_orphan_ready", s_status_ready, 1'b1);
    checkOutput("t5_orphan_no_valid", m_status_valid, 4'b0000);
    commitCycle();
    applyStimulus(4'b0000, 1'b1, 1'b0, '0, 4'b1111);
    evalCycle();
    checkOutput("t5_err_orphan", err_orphan, 1'b1);
    commitCycle();

    // T6: asynchronous reset mid-burst with five in flight, then req3 wins from pointer 0
    for (int c = 0; c < 5; c++) begin
      applyStimulus('1, 1'b1, 1'b0, '0, '1);
      step();
    end
    applyStimulus('1, 1'b1, 1'b1, 8'h33, '1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("t6_rst_m_cmd_valid", m_cmd_valid, 1'b0);
    checkOutput("t6_rst_m_cmd_address", m_cmd_address, 64'h0);
    checkOutput("t6_rst_busy", busy, 1'b0);
    checkOutput("t6_rst_err_orphan", err_orphan, 1'b0);
    checkOutput("t6_rst_s_cmd_ready", s_cmd_ready, 4'b0000);
    checkOutput("t6_rst_m_status_valid", m_status_valid, 4'b0000);
    doReset();
    applyStimulus(4'b1000, 1'b1, 1'b0, '0, '1);
    evalCycle();
    checkOutput("t6_req3_granted", s_cmd_ready, 4'b1000);
    commitCycle();
    applyStimulus(4'b0000, 1'b1, 1'b0, '0, '1);
    evalCycle();
    checkOutput("t6_req3_address", m_cmd_address, 64'h4000);
    commitCycle();
    drain();

    // Randomized traffic, alternating slow and fast status return to reach limits and FIFO full
    for (int c = 0; c < 3000; c++) begin
      bit slow;
      slow = ((c / 200) % 2) == 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        s_cmd_address[i*ADDR_W +: ADDR_W] = {$urandom, $urandom};
        s_cmd_length[i*LEN_W +: LEN_W]    = $urandom;
      end
      applyStimulus(NUM_REQ'($urandom), ($urandom_range(3) != 0),
                    slow ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0),
                    STS_W'($urandom), NUM_REQ'($urandom));
      step();
    end
    drain();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
